// File: rtl/vector_cache_pkg.sv
// Shared types and sizing constants for the vector cache evict path.
//   evict_to_ds_pld_t : one beat from the evict data buffer to the downstream stage.
//   ds_aw_pld_t       : write-address payload issued to next-level memory.
package vector_cache_pkg;

  localparam int DATA_WIDTH           = 1024;
  localparam int ADDR_WIDTH           = 48;
  localparam int TXNID_WIDTH          = 8;
  localparam int SIDEBAND_WIDTH       = 8;
  localparam int MSHR_ENTRY_IDX_WIDTH = 6;
  localparam int DB_ENTRY_IDX_WIDTH   = 4;

  localparam int EVICT_OST_NUM        = 8;
  localparam int EVICT_W_FIFO_DEPTH   = 8;
  localparam int EVICT_BEATS_PER_LINE = 4;
  localparam int EVICT_ID_WIDTH       = $clog2(EVICT_OST_NUM);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]           data;
    logic [ADDR_WIDTH-1:0]           addr;
    logic [TXNID_WIDTH-1:0]          txnid;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob_entry_id;
    logic [DB_ENTRY_IDX_WIDTH-1:0]   db_entry_id;
    logic [SIDEBAND_WIDTH-1:0]       sideband;
    logic                            last;
  } evict_to_ds_pld_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [EVICT_ID_WIDTH-1:0] id;
    logic [TXNID_WIDTH-1:0]    txnid;
    logic [SIDEBAND_WIDTH-1:0] sideband;
  } ds_aw_pld_t;

endpackage

// File: rtl/evict_w_fifo.sv
// Synchronous FIFO for write-data beats.
//   push/push_data : write side, ignored when full unless a pop happens in the same cycle.
//   pop/pop_data   : read side; pop_data is the head entry, read straight out of storage
//                    flops, so a pushed beat is visible one cycle after the push.
//   full/empty     : occupancy flags derived from pointers carrying one extra wrap bit.
module evict_w_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Equal index with differing wrap bit means the writer has lapped the reader.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/evict_ds_wr_ctrl.sv
// Downstream write controller of the evict data buffer.
// Takes BEATS_PER_LINE beats per evicted line, issues one write address (ds_aw) and
// the data beats (ds_w) to next-level memory, tracks each line in an outstanding slot
// whose index is the write id, and reports completion (evict_done) once ds_b returns.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   evict_to_ds_vld/pld/rdy          beat input
//   ds_aw_vld/pld/rdy                write address (registered, held until accepted)
//   ds_w_vld/data/last/rdy           write data from the beat FIFO
//   ds_b_vld/ds_b_id                 write response, always accepted
//   evict_done_vld/rob_idx           one-cycle completion pulse with the stored ROB index
//   proto_err                        sticky upstream/response protocol error
//
// Handshake rule for every channel: a transfer happens on a rising clk edge where
// vld && rdy; a producer holding vld keeps its payload stable until that edge, and
// vld never waits on rdy.
//
// Requires OST_NUM and W_FIFO_DEPTH to be powers of two and BEATS_PER_LINE >= 2.
module evict_ds_wr_ctrl
  import vector_cache_pkg::*;
#(
  parameter int OST_NUM        = EVICT_OST_NUM,
  parameter int W_FIFO_DEPTH   = EVICT_W_FIFO_DEPTH,
  parameter int BEATS_PER_LINE = EVICT_BEATS_PER_LINE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             evict_to_ds_vld,
  input  evict_to_ds_pld_t                 evict_to_ds_pld,
  output logic                             evict_to_ds_rdy,
  output logic                             ds_aw_vld,
  output ds_aw_pld_t                       ds_aw_pld,
  input  logic                             ds_aw_rdy,
  output logic                             ds_w_vld,
  output logic [DATA_WIDTH-1:0]            ds_w_data,
  output logic                             ds_w_last,
  input  logic                             ds_w_rdy,
  input  logic                             ds_b_vld,
  input  logic [$clog2(OST_NUM)-1:0]       ds_b_id,
  output logic                             evict_done_vld,
  output logic [MSHR_ENTRY_IDX_WIDTH-1:0]  evict_done_rob_idx,
  output logic                             proto_err
);

  localparam int ID_W  = $clog2(OST_NUM);
  localparam int CNT_W = $clog2(BEATS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_LINE - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,  // waiting for the first beat of a line
    ST_BURST = 1'b1   // collecting the remaining beats of the current line
  } state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic [OST_NUM-1:0]              slot_busy;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] slot_rob [OST_NUM];

  logic                  slot_avail;
  logic [ID_W-1:0]       alloc_id;
  logic                  aw_free;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  in_hs;
  logic                  final_beat;
  logic                  push_last;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  unused_pld_bits;

  assign unused_pld_bits = ^evict_to_ds_pld.db_entry_id;

  // Lowest-index free slot, from the registered busy vector only: a slot released by
  // ds_b this cycle is still seen as busy and becomes allocatable next cycle.
  always_comb begin
    alloc_id   = '0;
    slot_avail = 1'b0;
    for (int i = OST_NUM - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        alloc_id   = ID_W'(i);
        slot_avail = 1'b1;
      end
    end
  end

  // The AW register can take a new line while its current content is being accepted.
  assign aw_free = !ds_aw_vld || ds_aw_rdy;

  assign evict_to_ds_rdy = (state == ST_IDLE) ? (!fifo_full && slot_avail && aw_free)
                                              : !fifo_full;
  assign in_hs      = evict_to_ds_vld && evict_to_ds_rdy;
  assign final_beat = (state == ST_BURST) && (cnt == LAST_CNT);
  // w_last follows the beat count, not the upstream flag, so downstream always sees
  // well-formed bursts even when upstream misplaces last.
  assign push_last  = final_beat;

  evict_w_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (W_FIFO_DEPTH)
  ) u_w_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_hs),
    .push_data ({evict_to_ds_pld.data, push_last}),
    .pop       (ds_w_rdy),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ds_w_vld  = !fifo_empty;
  assign ds_w_data = fifo_dout[DATA_WIDTH:1];
  assign ds_w_last = fifo_dout[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      ds_aw_vld          <= 1'b0;
      ds_aw_pld          <= '0;
      slot_busy          <= '0;
      evict_done_vld     <= 1'b0;
      evict_done_rob_idx <= '0;
      proto_err          <= 1'b0;
    end else begin
      evict_done_vld <= 1'b0;

      if (ds_aw_vld && ds_aw_rdy) ds_aw_vld <= 1'b0;

      // Response: retire a busy slot, or flag a response for an id never issued.
      if (ds_b_vld) begin
        if (slot_busy[ds_b_id]) begin
          slot_busy[ds_b_id] <= 1'b0;
          evict_done_vld     <= 1'b1;
          evict_done_rob_idx <= slot_rob[ds_b_id];
        end else begin
          proto_err <= 1'b1;
        end
      end

      if (in_hs) begin
        case (state)
          ST_IDLE: begin
            ds_aw_vld          <= 1'b1;
            ds_aw_pld.addr     <= evict_to_ds_pld.addr;
            ds_aw_pld.id       <= alloc_id;
            ds_aw_pld.txnid    <= evict_to_ds_pld.txnid;
            ds_aw_pld.sideband <= evict_to_ds_pld.sideband;
            slot_busy[alloc_id] <= 1'b1;
            if (evict_to_ds_pld.last) proto_err <= 1'b1;
            cnt   <= CNT_W'(1);
            state <= ST_BURST;
          end
          ST_BURST: begin
            if (final_beat) begin
              if (!evict_to_ds_pld.last) proto_err <= 1'b1;
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              if (evict_to_ds_pld.last) proto_err <= 1'b1;
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // ROB index storage is only read for busy slots, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_hs && (state == ST_IDLE)) slot_rob[alloc_id] <= evict_to_ds_pld.rob_entry_id;
  end

endmodule

// File: tb/tb_evict_ds_wr_ctrl.sv
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      failures++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_evict_ds_wr_ctrl;
  import vector_cache_pkg::*;

  localparam int OST   = 8;
  localparam int DEPTH = 8;
  localparam int BPL   = 4;
  localparam int AWB   = $bits(ds_aw_pld_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                            evict_to_ds_vld = 1'b0;
  evict_to_ds_pld_t                evict_to_ds_pld = '0;
  logic                            evict_to_ds_rdy;
  logic                            ds_aw_vld;
  ds_aw_pld_t                      ds_aw_pld;
  logic                            ds_aw_rdy = 1'b0;
  logic                            ds_w_vld;
  logic [DATA_WIDTH-1:0]           ds_w_data;
  logic                            ds_w_last;
  logic                            ds_w_rdy = 1'b0;
  logic                            ds_b_vld = 1'b0;
  logic [2:0]                      ds_b_id = '0;
  logic                            evict_done_vld;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] evict_done_rob_idx;
  logic                            proto_err;

  evict_ds_wr_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .evict_to_ds_vld    (evict_to_ds_vld),
    .evict_to_ds_pld    (evict_to_ds_pld),
    .evict_to_ds_rdy    (evict_to_ds_rdy),
    .ds_aw_vld          (ds_aw_vld),
    .ds_aw_pld          (ds_aw_pld),
    .ds_aw_rdy          (ds_aw_rdy),
    .ds_w_vld           (ds_w_vld),
    .ds_w_data          (ds_w_data),
    .ds_w_last          (ds_w_last),
    .ds_w_rdy           (ds_w_rdy),
    .ds_b_vld           (ds_b_vld),
    .ds_b_id            (ds_b_id),
    .evict_done_vld     (evict_done_vld),
    .evict_done_rob_idx (evict_done_rob_idx),
    .proto_err          (proto_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus knobs (percent chance per cycle).
  int vld_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 0;
  bit b_force = 1'b0;
  logic [2:0] b_force_id = '0;

  evict_to_ds_pld_t beat_q[$];

  // ---------------- reference model / scoreboard ----------------
  // A line is BPL beats; its first beat takes the lowest free slot (as of the start of
  // the cycle); one address per line; beats come out in order with last on beat BPL.
  int                              in_pos = 0;
  bit                              m_busy[OST];
  bit                              m_aw_seen[OST];
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] m_rob[OST];
  int                              m_fifo_occ = 0;
  int                              m_aw_pend = 0;
  bit                              m_proto = 1'b0;
  logic [DATA_WIDTH:0]             exp_q[$];
  logic [AWB-1:0]                  exp_aw_q[$];
  bit                              exp_done = 1'b0;
  logic [MSHR_ENTRY_IDX_WIDTH-1:0] exp_done_rob = '0;

  int beats_acc = 0, done_cnt = 0, last_done_rob = -1;
  int first_acc_cyc = -1, first_acc_id = -1, aw_hs_cyc = -1, b_cyc = -1;

  function automatic int lowest_free();
    for (int i = 0; i < OST; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit any_busy();
    for (int i = 0; i < OST; i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    beat_q.delete();
    exp_q.delete();
    exp_aw_q.delete();
    for (int i = 0; i < OST; i++) begin
      m_busy[i] = 1'b0;
      m_aw_seen[i] = 1'b0;
    end
    in_pos = 0; m_fifo_occ = 0; m_aw_pend = 0; m_proto = 1'b0; exp_done = 1'b0;
  endtask

  // Called at the falling edge: inputs and DUT outputs are stable for the coming edge.
  task automatic observe();
    evict_to_ds_pld_t p;
    ds_aw_pld_t       e;
    logic [AWB-1:0]   ev;
    logic [DATA_WIDTH:0] ew;
    bit  exp_rdy, proto_set, new_done;
    int  id;
    logic [MSHR_ENTRY_IDX_WIDTH-1:0] new_rob;
    proto_set = 1'b0; new_done = 1'b0; new_rob = '0;

    `CHK("done_vld", evict_done_vld, exp_done)
    if (exp_done) `CHK("done_rob", evict_done_rob_idx, exp_done_rob)
    if (evict_done_vld) begin
      done_cnt++;
      last_done_rob = int'(evict_done_rob_idx);
    end
    `CHK("proto_err", proto_err, m_proto)
    `CHK("w_vld", ds_w_vld, (m_fifo_occ > 0))
    `CHK("aw_vld", ds_aw_vld, (m_aw_pend > 0))

    if (evict_to_ds_vld) begin
      if (in_pos == 0) exp_rdy = (m_fifo_occ < DEPTH) && (lowest_free() >= 0) &&
                                 ((m_aw_pend == 0) || ds_aw_rdy);
      else             exp_rdy = (m_fifo_occ < DEPTH);
      `CHK("evict_rdy", evict_to_ds_rdy, exp_rdy)
    end

    if (ds_aw_vld && ds_aw_rdy) begin
      `CHK("aw_q_nonempty", (exp_aw_q.size() != 0), 1'b1)
      if (exp_aw_q.size() != 0) begin
        ev = exp_aw_q.pop_front();
        e  = ds_aw_pld_t'(ev);
        `CHK("aw_pld", ds_aw_pld, e)
        m_aw_seen[e.id] = 1'b1;
        m_aw_pend--;
        aw_hs_cyc = cyc;
      end
    end

    if (evict_to_ds_vld && evict_to_ds_rdy && beat_q.size() != 0) begin
      p = beat_q.pop_front();
      beats_acc++;
      if (in_pos == 0) begin
        id = lowest_free();
        if (id < 0) id = 0;
        m_busy[id] = 1'b1;
        m_aw_seen[id] = 1'b0;
        m_rob[id] = p.rob_entry_id;
        e.addr = p.addr; e.id = 3'(id); e.txnid = p.txnid; e.sideband = p.sideband;
        exp_aw_q.push_back(e);
        m_aw_pend++;
        first_acc_cyc = cyc;
        first_acc_id  = id;
      end
      if (p.last != (in_pos == BPL - 1)) proto_set = 1'b1;
      exp_q.push_back({p.data, (in_pos == BPL - 1)});
      m_fifo_occ++;
      in_pos = (in_pos + 1) % BPL;
    end

    if (ds_w_vld && ds_w_rdy) begin
      `CHK("w_q_nonempty", (exp_q.size() != 0), 1'b1)
      if (exp_q.size() != 0) begin
        ew = exp_q.pop_front();
        checks++;
        assert (ds_w_data === ew[DATA_WIDTH:1]) else begin
          failures++;
          $error("FAIL w_data: observed[63:0]=%h expected[63:0]=%h", ds_w_data[63:0], ew[64:1]);
        end
        `CHK("w_last", ds_w_last, ew[0])
        m_fifo_occ--;
      end
    end

    if (ds_b_vld) begin
      if (m_busy[ds_b_id]) begin
        m_busy[ds_b_id] = 1'b0;
        m_aw_seen[ds_b_id] = 1'b0;
        new_done = 1'b1;
        new_rob  = m_rob[ds_b_id];
        b_cyc    = cyc;
      end else begin
        proto_set = 1'b1;
      end
    end

    exp_done = new_done;
    exp_done_rob = new_rob;
    if (proto_set) m_proto = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    int cand[$];
    evict_to_ds_vld = (beat_q.size() != 0) && ($urandom_range(99) < 32'(vld_pct));
    if (beat_q.size() != 0) evict_to_ds_pld = beat_q[0];
    ds_aw_rdy = ($urandom_range(99) < 32'(aw_pct));
    ds_w_rdy  = ($urandom_range(99) < 32'(w_pct));
    ds_b_vld  = 1'b0;
    if (b_force) begin
      ds_b_vld = 1'b1;
      ds_b_id  = b_force_id;
      b_force  = 1'b0;
    end else if ($urandom_range(99) < 32'(b_pct)) begin
      for (int i = 0; i < OST; i++) if (m_busy[i] && m_aw_seen[i]) cand.push_back(i);
      if (cand.size() != 0) begin
        ds_b_vld = 1'b1;
        ds_b_id  = 3'(cand[$urandom_range(cand.size() - 1)]);
      end
    end
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add_line(input logic [ADDR_WIDTH-1:0] addr,
                          input logic [MSHR_ENTRY_IDX_WIDTH-1:0] rob,
                          input logic [3:0] last_pat);
    evict_to_ds_pld_t p;
    p = '0;
    p.addr = addr;
    p.rob_entry_id = rob;
    p.txnid = 8'($urandom);
    p.sideband = 8'($urandom);
    p.db_entry_id = 4'($urandom);
    for (int b = 0; b < BPL; b++) begin
      for (int k = 0; k < DATA_WIDTH / 32; k++) p.data[k*32 +: 32] = $urandom;
      p.last = last_pat[b];
      beat_q.push_back(p);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((beat_q.size() != 0 || exp_q.size() != 0 || exp_aw_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    `CHK("drain_in_budget", (n < max), 1'b1)
  endtask

  task automatic free_all(input int max);
    int n = 0;
    int saved = b_pct;
    b_pct = 100;
    while (any_busy() && n < max) begin
      tick();
      n++;
    end
    tick();
    b_pct = saved;
    `CHK("free_in_budget", (n < max), 1'b1)
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    evict_to_ds_vld = 1'b0;
    ds_b_vld = 1'b0;
    b_force = 1'b0;
    model_clear();
    #2;
    `CHK("rst_aw_vld", ds_aw_vld, 1'b0)
    `CHK("rst_w_vld", ds_w_vld, 1'b0)
    `CHK("rst_done_vld", evict_done_vld, 1'b0)
    `CHK("rst_proto_err", proto_err, 1'b0)
    @(posedge clk);
    #1;
    `CHK("rst_hold_aw_vld", ds_aw_vld, 1'b0)
    `CHK("rst_hold_w_vld", ds_w_vld, 1'b0)
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    ds_aw_pld_t saved_aw;

    model_clear();
    #3;
    do_reset();
    `CHK("rst_evict_rdy", evict_to_ds_rdy, 1'b1)

    // Single line: addr 0x1000, rob 3.
    add_line(48'h1000, 6'd3, 4'b1000);
    drain(100);
    `CHK("single_aw_latency", aw_hs_cyc - first_acc_cyc, 1)
    `CHK("single_slot", first_acc_id, 0)
    base = done_cnt;
    b_force = 1'b1; b_force_id = 3'd0;
    run(2);
    `CHK("single_done_cnt", done_cnt - base, 1)
    `CHK("single_done_rob", last_done_rob, 3)

    // Slots exhausted: eight lines without responses, ninth blocked until B id 5.
    for (int l = 0; l < OST; l++) add_line(48'($urandom) << 7, 6'(l + 8), 4'b1000);
    drain(200);
    add_line(48'h2_0000, 6'd40, 4'b1000);
    run(4);
    `CHK("ninth_blocked", beat_q.size(), BPL)
    b_force = 1'b1; b_force_id = 3'd5;
    run(2);
    `CHK("ninth_slot", first_acc_id, 5)
    `CHK("ninth_after_b", first_acc_cyc - b_cyc, 1)
    drain(100);
    free_all(200);

    // W backpressure: FIFO fills at eight beats.
    w_pct = 0;
    base = beats_acc;
    for (int l = 0; l < 3; l++) add_line(48'($urandom) << 7, 6'(l + 20), 4'b1000);
    run(16);
    `CHK("bp_accepted", beats_acc - base, DEPTH)
    `CHK("bp_rdy_low", evict_to_ds_rdy, 1'b0)
    w_pct = 100;
    drain(200);
    free_all(200);

    // AW stall for ten cycles: payload stable, current burst still drains.
    aw_pct = 0;
    add_line(48'h3_0000, 6'd30, 4'b1000);
    add_line(48'h4_0000, 6'd31, 4'b1000);
    tick();
    saved_aw = ds_aw_pld;
    `CHK("stall_aw_vld", ds_aw_vld, 1'b1)
    for (int i = 0; i < 9; i++) begin
      tick();
      `CHK("stall_aw_stable", ds_aw_pld, saved_aw)
    end
    `CHK("stall_burst_done", beat_q.size(), BPL)
    aw_pct = 100;
    drain(200);
    free_all(200);

    // Randomized traffic.
    vld_pct = 70; aw_pct = 60; w_pct = 60; b_pct = 30;
    for (int l = 0; l < 30; l++) add_line(48'($urandom) << 7, 6'($urandom), 4'b1000);
    drain(5000);
    free_all(500);
    vld_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 0;

    // Misplaced last: early on beat 2, missing on beat 4.
    add_line(48'h5_0000, 6'd50, 4'b0010);
    drain(100);
    run(3);
    `CHK("proto_sticky", proto_err, 1'b1)
    free_all(100);

    // Reset with three lines outstanding and a line half sent.
    for (int l = 0; l < 3; l++) add_line(48'($urandom) << 7, 6'(l + 60), 4'b1000);
    drain(100);
    add_line(48'h6_0000, 6'd33, 4'b1000);
    run(2);
    do_reset();
    add_line(48'h7_0000, 6'd34, 4'b1000);
    drain(100);
    `CHK("post_reset_slot", first_acc_id, 0)

    // Response on a free id: error, no completion.
    base = done_cnt;
    b_force = 1'b1; b_force_id = 3'd2;
    run(3);
    `CHK("bfree_proto", proto_err, 1'b1)
    `CHK("bfree_no_done", done_cnt - base, 0)
    free_all(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
